// File: rtl/viterbi_pkg.sv
// Shared constants and types for the K=3, rate-1/2 (7,5) code.
// Used by the frame encoder and the decoder's branch-metric reference.
package viterbi_pkg;

  localparam int K = 3;
  localparam logic [K-1:0] G0 = 3'b111;
  localparam logic [K-1:0] G1 = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    ENCODE,
    DONE
  } state_e;

endpackage

// File: rtl/conv_encoder_frame_if.sv
// Request/result bundle between a frame source and conv_encoder_frame.
// The slave side is the encoder; the master side drives requests.
interface conv_encoder_frame_if #(
  parameter int SIZE_DATA_IN  = 8,
  parameter int SIZE_DATA_OUT = 16
);

  logic                     i_start;
  logic [SIZE_DATA_IN-1:0]  i_data;
  logic [SIZE_DATA_OUT-1:0] i_err_mask;
  logic [1:0]               o_sym;
  logic                     o_sym_valid;
  logic [SIZE_DATA_OUT-1:0] o_data;
  logic                     o_busy;
  logic                     o_done;

  modport master (
    output i_start,
    output i_data,
    output i_err_mask,
    input  o_sym,
    input  o_sym_valid,
    input  o_data,
    input  o_busy,
    input  o_done
  );

  modport slave (
    input  i_start,
    input  i_data,
    input  i_err_mask,
    output o_sym,
    output o_sym_valid,
    output o_data,
    output o_busy,
    output o_done
  );

endinterface

// File: rtl/conv_enc_core.sv
// K=3 convolutional encoder core: {d1,d2} history plus generator taps.
// Synchronous clear wins over enable so a new frame restarts from 00.
module conv_enc_core
  import viterbi_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       clr,
  input  logic       u,
  output logic [1:0] sym
);

  logic [K-2:0] hist;
  logic [K-1:0] win;

  assign win = {u, hist};
  assign sym = {^(win & G0), ^(win & G1)};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist <= '0;
    end else if (clr) begin
      hist <= '0;
    end else if (en) begin
      hist <= {u, hist[K-2:1]};
    end
  end

endmodule

// File: rtl/conv_encoder_frame.sv
// Frame-based (7,5) convolutional encoder: one message bit per cycle,
// MSB first, emitting the masked encoded word with a one-cycle done.
module conv_encoder_frame #(
  parameter int SIZE_DATA_IN  = 8,
  parameter int SIZE_DATA_OUT = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  conv_encoder_frame_if.slave   bus
);

  import viterbi_pkg::*;

  localparam int CW = (SIZE_DATA_IN > 1) ? $clog2(SIZE_DATA_IN) : 1;
  localparam logic [CW-1:0] LAST = CW'(SIZE_DATA_IN - 1);

  state_e state, state_nxt;

  logic [SIZE_DATA_IN-1:0]  msg;
  logic [SIZE_DATA_OUT-1:0] mask;
  logic [SIZE_DATA_OUT-1:0] acc;
  logic [SIZE_DATA_OUT-1:0] acc_nxt;
  logic [SIZE_DATA_OUT-1:0] data_q;
  logic [CW-1:0]            cnt;
  logic [1:0]               sym;
  logic                     load;
  logic                     enc_en;
  logic                     last;

  assign load   = (state == IDLE) && bus.i_start;
  assign enc_en = (state == ENCODE);
  assign last   = (cnt == LAST);

  conv_enc_core u_core (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .en    (enc_en),
    .clr   (load),
    .u     (msg[SIZE_DATA_IN-1]),
    .sym   (sym)
  );

  // First symbol ends up in the top two bits after the final shift.
  assign acc_nxt = {acc[SIZE_DATA_OUT-3:0], sym};

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.i_start) state_nxt = ENCODE;
      ENCODE:  if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      msg    <= '0;
      mask   <= '0;
      acc    <= '0;
      cnt    <= '0;
      data_q <= '0;
    end else if (load) begin
      msg  <= bus.i_data;
      mask <= bus.i_err_mask;
      acc  <= '0;
      cnt  <= '0;
    end else if (enc_en) begin
      msg <= {msg[SIZE_DATA_IN-2:0], 1'b0};
      acc <= acc_nxt;
      cnt <= cnt + 1'b1;
      // Publish on the final bit so o_data is already valid with o_done.
      if (last) data_q <= acc_nxt ^ mask;
    end
  end

  assign bus.o_sym       = enc_en ? sym : 2'b00;
  assign bus.o_sym_valid = enc_en;
  assign bus.o_busy      = (state != IDLE);
  assign bus.o_done      = (state == DONE);
  assign bus.o_data      = data_q;

endmodule

// File: tb/tb_conv_encoder_frame.sv
// Randomized bench for conv_encoder_frame against a bit-level
// arithmetic model of the (7,5) code.
module tb_conv_encoder_frame;

  localparam int N = 8;
  localparam int W = 16;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  conv_encoder_frame_if #(.SIZE_DATA_IN(N), .SIZE_DATA_OUT(W)) bus ();

  conv_encoder_frame #(
    .SIZE_DATA_IN  (N),
    .SIZE_DATA_OUT (W)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int ref_encode(input int d);
    int s1, s2, w, u, g0, g1;
    s1 = 0;
    s2 = 0;
    w  = 0;
    for (int i = N - 1; i >= 0; i--) begin
      u  = (d >> i) % 2;
      g0 = (u + s1 + s2) % 2;
      g1 = (u + s2) % 2;
      w  = w * 4 + g0 * 2 + g1;
      s2 = s1;
      s1 = u;
    end
    return w;
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, bus.o_busy, 0);
    chk({tag, "_done"}, bus.o_done, 0);
    chk({tag, "_vld"}, bus.o_sym_valid, 0);
    chk({tag, "_sym"}, bus.o_sym, 0);
  endtask

  // Called just after a negedge; returns just after the cycle-10 negedge.
  task automatic run_frame(input int d, input int m, input bit junk);
    int word, sym_exp;
    word = ref_encode(d);
    bus.i_start    = 1'b1;
    bus.i_data     = N'(d);
    bus.i_err_mask = W'(m);
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      bus.i_start    = junk ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.i_data     = N'($urandom);
      bus.i_err_mask = W'($urandom);
      sym_exp = (word >> (2 * (N - 1 - k))) % 4;
      chk($sformatf("sym%0d", k), bus.o_sym, sym_exp);
      chk($sformatf("vld%0d", k), bus.o_sym_valid, 1);
      chk($sformatf("busy%0d", k), bus.o_busy, 1);
      chk($sformatf("done%0d", k), bus.o_done, 0);
    end
    @(negedge clk);
    bus.i_start = 1'b0;
    chk("done_pulse", bus.o_done, 1);
    chk("done_busy", bus.o_busy, 1);
    chk("done_vld", bus.o_sym_valid, 0);
    chk($sformatf("data_%0h", d), bus.o_data, (word ^ m) & 16'hFFFF);
    @(negedge clk);
    chk_idle("post");
    chk("hold", bus.o_data, (word ^ m) & 16'hFFFF);
  endtask

  task automatic quiet(input int n, input logic [31:0] hold);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.i_data     = N'($urandom);
      bus.i_err_mask = W'($urandom);
      chk("q_done", bus.o_done, 0);
      chk("q_busy", bus.o_busy, 0);
      chk("q_hold", bus.o_data, hold);
    end
  endtask

  initial begin
    int d, m;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.i_start = 1'b0;
    bus.i_data = '0;
    bus.i_err_mask = '0;
    repeat (3) @(negedge clk);
    chk_idle("rst");
    chk("rst_data", bus.o_data, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle("rel");

    chk("model_80", ref_encode(8'h80), 16'hEC00);
    chk("model_ff", ref_encode(8'hFF), 16'hDAAA);

    run_frame(8'h80, 0, 1'b0);
    run_frame(8'hFF, 0, 1'b0);
    run_frame(8'h00, 0, 1'b0);
    run_frame(8'h80, 16'h0001, 1'b0);
    quiet(3, 16'hEC01);

    // Requests during busy must be dropped, not queued.
    @(negedge clk);
    run_frame(8'h5A, 0, 1'b1);
    quiet(12, ref_encode(8'h5A));

    // Back-to-back frames must not leak encoder history.
    run_frame(8'h80, 0, 1'b0);
    run_frame(8'hFF, 0, 1'b0);

    for (int f = 0; f < 8; f++) begin
      d = int'($urandom_range(0, 255));
      m = int'($urandom_range(0, 65535));
      run_frame(d, m, 1'b1);
    end

    // Mid-frame asynchronous reset.
    bus.i_start = 1'b1;
    bus.i_data  = 8'hC3;
    bus.i_err_mask = 16'hFFFF;
    @(negedge clk);
    bus.i_start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_idle("arst");
    chk("arst_data", bus.o_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    quiet(12, 0);
    run_frame(8'hFF, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
